// File: rtl/sequence_encoder.sv
// Serial pattern transmitter: parallel words in over valid/ready, one bit per clock out,
// with a one-word holding buffer and a running 101/110 detection reference count.
module sequence_encoder #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0,
    localparam int LEN_W     = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sequence_out,
    output logic             out_active,
    output logic             frame_done,
    output logic [15:0]      expect_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   shift_r, shift_s;
    logic [LEN_W-1:0]   cnt_r, cnt_s;
    logic               seq_r, seq_s;
    logic               active_r, active_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   buf_data_r, buf_data_s;
    logic [LEN_W-1:0]   buf_len_r, buf_len_s;
    logic               buf_full_r, buf_full_s;
    logic [2:0]         hist_r, hist_s;
    logic [15:0]        count_r, count_s;

    logic               accept_s;
    logic               free_s;
    logic               load_buf_s;
    logic               load_in_s;
    logic               load_s;
    logic [WIDTH-1:0]   load_data_s;
    logic [LEN_W-1:0]   eff_len_s;
    logic [WIDTH-1:0]   aligned_s;

    // A length of zero or beyond the shifter means a full-width frame.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
        if (len == LEN_ZERO || 32'(len) > WIDTH) begin
            return LEN_MAX;
        end else begin
            return len;
        end
    endfunction

    assign in_ready    = !buf_full_r && !reset;
    assign accept_s    = in_valid && in_ready;
    // The shifter is free when nothing is in flight or its last bit is on the line now.
    assign free_s      = (state_r == IDLE) || (cnt_r == LEN_ZERO);
    assign load_buf_s  = free_s && buf_full_r;
    assign load_in_s   = free_s && !buf_full_r && accept_s;
    assign load_s      = load_buf_s || load_in_s;
    assign load_data_s = buf_full_r ? buf_data_r : data_in;
    assign eff_len_s   = norm_len(buf_full_r ? buf_len_r : len_in);
    assign aligned_s   = load_data_s << (LEN_MAX - eff_len_s);

    // Next-state, shifter, buffer and detection-count logic.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        cnt_s      = cnt_r;
        seq_s      = seq_r;
        active_s   = active_r;
        done_s     = done_r;
        buf_data_s = buf_data_r;
        buf_len_s  = buf_len_r;
        buf_full_s = buf_full_r;
        hist_s     = {hist_r[1:0], seq_r};
        count_s    = count_r;

        if (load_s) begin
            cnt_s    = eff_len_s - LEN_ONE;
            active_s = 1'b1;
            done_s   = (eff_len_s == LEN_ONE);
            state_s  = (eff_len_s == LEN_ONE) ? IDLE : SHIFT;
            if (LSB_FIRST) begin
                seq_s   = load_data_s[0];
                shift_s = {1'b0, load_data_s[WIDTH-1:1]};
            end else begin
                seq_s   = aligned_s[WIDTH-1];
                shift_s = {aligned_s[WIDTH-2:0], 1'b0};
            end
        end else if (state_r == SHIFT && cnt_r != LEN_ZERO) begin
            cnt_s    = cnt_r - LEN_ONE;
            active_s = 1'b1;
            done_s   = (cnt_r == LEN_ONE);
            state_s  = SHIFT;
            if (LSB_FIRST) begin
                seq_s   = shift_r[0];
                shift_s = {1'b0, shift_r[WIDTH-1:1]};
            end else begin
                seq_s   = shift_r[WIDTH-1];
                shift_s = {shift_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            state_s  = IDLE;
            cnt_s    = LEN_ZERO;
            seq_s    = IDLE_LEVEL;
            active_s = 1'b0;
            done_s   = 1'b0;
        end

        // Acceptance needs an empty buffer, so draining and refilling never coincide.
        if (load_buf_s) begin
            buf_full_s = 1'b0;
        end else if (accept_s && !load_in_s) begin
            buf_full_s = 1'b1;
            buf_data_s = data_in;
            buf_len_s  = len_in;
        end else begin
            buf_full_s = buf_full_r;
        end

        if ((hist_s == 3'b101 || hist_s == 3'b110) && count_r != 16'hFFFF) begin
            count_s = count_r + 16'd1;
        end else begin
            count_s = count_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= {WIDTH{1'b0}};
            cnt_r      <= LEN_ZERO;
            seq_r      <= IDLE_LEVEL;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
            buf_data_r <= {WIDTH{1'b0}};
            buf_len_r  <= LEN_ZERO;
            buf_full_r <= 1'b0;
            hist_r     <= 3'b000;
            count_r    <= 16'd0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            cnt_r      <= cnt_s;
            seq_r      <= seq_s;
            active_r   <= active_s;
            done_r     <= done_s;
            buf_data_r <= buf_data_s;
            buf_len_r  <= buf_len_s;
            buf_full_r <= buf_full_s;
            hist_r     <= hist_s;
            count_r    <= count_s;
        end
    end

    assign sequence_out = seq_r;
    assign out_active   = active_r;
    assign frame_done   = done_r;
    assign expect_count = count_r;

endmodule
